booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter N, default 16: operand width in bits; the product is 2N bits.
REQ-002 Parameter NREQ, default 4: number of requesters; must be at least 2.
REQ-003 Parameter TIMEOUT, default 64: maximum number of WAIT cycles before an operation is aborted.
REQ-004 Port clk, input, width 1: single clock; all state updates on the rising edge.
REQ-005 Port reset, input, width 1: asynchronous reset, active-high.
REQ-006 Port req_valid, input, width NREQ: per-requester request valid.
REQ-007 Port req_a, input, width NREQ*N: signed multiplicand; requester i uses slice [i*N +: N].
REQ-008 Port req_b, input, width NREQ*N: signed multiplier, sliced the same way as req_a.
REQ-009 Port req_ready, output, width NREQ: per-requester accept strobe; at most one bit high.
REQ-010 Port rsp_valid, output, width 1: response valid.
REQ-011 Port rsp_id, output, width clog2(NREQ): index of the requester that owns the response.
REQ-012 Port rsp_data, output, width 2N: signed product.
REQ-013 Port rsp_err, output, width 1: the response was aborted by timeout; rsp_data is 0.
REQ-014 Port rsp_ready, input, width 1: response consumer ready.
REQ-015 Port mul_a and mul_b, output, width N each: registered operands to the shared Booth multiplier.
REQ-016 Port mul_start, output, width 1: one-cycle pulse that loads the multiplier.
REQ-017 Port mul_out, input, width 2N: product from the multiplier.
REQ-018 Port mul_done, input, width 1: multiplier flag; high means mul_out is final.
REQ-019 Port busy, output, width 1: high in any state other than IDLE.

Function
REQ-020 The FSM SHALL have four states: IDLE, START, WAIT, RESP.
REQ-021 IDLE: the grant SHALL go to the first requester with req_valid=1, searching round-robin from pointer ptr; only that requester's req_ready bit is high, combinationally.
REQ-022 On a valid&ready handshake, the block SHALL latch mul_a/mul_b from the granted slices, latch the grant index as rsp_id, and move to START.
REQ-023 START SHALL assert mul_start for exactly one cycle, clear the cycle counter, and move to WAIT.
REQ-024 WAIT SHALL increment the counter every cycle. When mul_done=1 it SHALL capture mul_out into rsp_data, set rsp_err=0, and move to RESP.
REQ-025 If the counter reaches TIMEOUT in WAIT with mul_done=0, the block SHALL set rsp_err=1 and rsp_data=0 and move to RESP.
REQ-026 If mul_done and the timeout occur in the same cycle, mul_done SHALL win.
REQ-027 mul_done SHALL be ignored outside WAIT; the multiplier deasserts done within one cycle of mul_start.
REQ-028 RESP SHALL hold rsp_valid, rsp_id, rsp_data and rsp_err stable until rsp_ready=1.
REQ-029 On the RESP handshake, ptr SHALL become (rsp_id+1) mod NREQ and the FSM SHALL return to IDLE.
REQ-030 req_ready SHALL be 0 in every state except IDLE; new requests cannot be accepted in the RESP handshake cycle.
REQ-031 Minimum latency from request handshake to rsp_valid SHALL be 2 cycles plus the multiplier latency.
REQ-032 A requester deasserting req_valid before its grant SHALL lose nothing: no state is kept for ungranted requesters.
REQ-033 Arithmetic SHALL be two's complement with no truncation; rsp_data equals the full 2N-bit mul_out.

Reset
REQ-034 While reset=1, the FSM SHALL be IDLE and ptr=0.
REQ-035 While reset=1, req_ready, rsp_valid, rsp_err, mul_start and busy SHALL be 0.
REQ-036 While reset=1, rsp_id, rsp_data, mul_a, mul_b and the counter SHALL be 0.
REQ-037 Reset asserted mid-operation SHALL discard the in-flight operation without producing a response.

Verification
REQ-038 Single request: req0 a=3, b=-5; multiplier done after 8 cycles -> one response with rsp_id=0, rsp_data=-15, rsp_err=0.
REQ-039 Contention: all four valid from reset -> grants in order 0,1,2,3; then with req2 and req0 valid after id 3 -> next grant is 0.
REQ-040 Backpressure: rsp_ready held low for 10 cycles in RESP -> outputs stable, req_ready all 0, exactly one handshake.
REQ-041 Timeout: mul_done tied low -> rsp_err=1 and rsp_data=0 after TIMEOUT WAIT cycles, then the next request is served normally.
REQ-042 Extremes: a=-32768, b=-32768 -> rsp_data=1073741824; a=32767, b=-32768 -> rsp_data=-1073709056.
REQ-043 Reset pulse during WAIT -> no rsp_valid, all outputs at reset values, and a subsequent request completes correctly.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter in front of a shared Booth multiplier: grants one requester,
// launches the multiply, waits for done or a timeout, and returns the tagged product.
module booth_mul_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*N-1:0]         req_a,
    input  logic [NREQ*N-1:0]         req_b,
    output logic [NREQ-1:0]           req_ready,
    output logic                      rsp_valid,
    output logic [$clog2(NREQ)-1:0]   rsp_id,
    output logic [2*N-1:0]            rsp_data,
    output logic                      rsp_err,
    input  logic                      rsp_ready,
    output logic [N-1:0]              mul_a,
    output logic [N-1:0]              mul_b,
    output logic                      mul_start,
    input  logic [2*N-1:0]            mul_out,
    input  logic                      mul_done,
    output logic                      busy
);

    localparam int unsigned IW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait, StResp} state_e;

    state_e          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   rsp_id_q;
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  rsp_data_q;
    logic [N-1:0]    mul_a_q, mul_b_q;
    logic            rsp_valid_q, rsp_err_q, mul_start_q, busy_q;

    logic            gnt_found;
    logic [IW-1:0]   gnt_idx;

    // Scan offsets from the highest down so the nearest requester after ptr wins.
    always_comb begin
        int j;
        logic [IW-1:0] cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        j         = 0;
        cand      = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(ptr_q) + i;
            if (j >= int'(NREQ)) j = j - int'(NREQ);
            cand = IW'(j);
            if (req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Gated by reset because the grant path is purely combinational.
    always_comb begin
        req_ready = '0;
        if (!reset && state_q == StIdle && gnt_found) req_ready = NREQ'(1) << gnt_idx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            ptr_q       <= '0;
            rsp_id_q    <= '0;
            cnt_q       <= '0;
            rsp_data_q  <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mul_start_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (gnt_found) begin
                        mul_a_q     <= req_a[gnt_idx*N +: N];
                        mul_b_q     <= req_b[gnt_idx*N +: N];
                        rsp_id_q    <= gnt_idx;
                        mul_start_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= StStart;
                    end
                end
                StStart: begin
                    mul_start_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_done) begin
                        rsp_data_q  <= mul_out;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        ptr_q       <= (rsp_id_q == IW'(NREQ - 1)) ? '0 : rsp_id_q + 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_start = mul_start_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Scoreboard bench for booth_mul_arbiter with a behavioural multiplier of programmable latency.
module tb_booth_mul_arbiter;

    localparam int N       = 16;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int IW      = 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*N-1:0]    req_a, req_b;
    logic [NREQ-1:0]      req_ready;
    logic                 rsp_valid;
    logic [IW-1:0]        rsp_id;
    logic [2*N-1:0]       rsp_data;
    logic                 rsp_err;
    logic                 rsp_ready;
    logic [N-1:0]         mul_a, mul_b;
    logic                 mul_start;
    logic [2*N-1:0]       mul_out;
    logic                 mul_done;
    logic                 busy;

    booth_mul_arbiter #(.N(N), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_ready(rsp_ready), .mul_a(mul_a), .mul_b(mul_b),
        .mul_start(mul_start), .mul_out(mul_out), .mul_done(mul_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Multiplier: done becomes visible mul_lat cycles after the mul_start cycle.
    int   mul_lat  = 8;
    logic mul_hang = 1'b0;
    int   mcnt;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mul_done <= 1'b0;
            mcnt     <= 0;
            mul_out  <= '0;
        end else if (mul_start) begin
            mul_done <= 1'b0;
            mcnt     <= mul_lat - 1;
            mul_out  <= $signed(mul_a) * $signed(mul_b);
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !mul_hang) mul_done <= 1'b1;
        end
    end

    typedef struct {
        logic [IW-1:0]  id;
        logic [2*N-1:0] data;
        logic           err;
    } exp_t;
    exp_t sb_q[$];

    int   n_chk = 0, n_err = 0, n_rsp = 0;
    int   cyc = 0, hs_cyc = 0, lat_obs = -1;
    logic rv_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic expect_rsp(input int id, input logic [2*N-1:0] data, input logic err);
        exp_t e;
        e.id   = IW'(id);
        e.data = data;
        e.err  = err;
        sb_q.push_back(e);
    endtask

    task automatic set_req(input int i, input int a, input int b);
        req_a[i*N +: N] = a[N-1:0];
        req_b[i*N +: N] = b[N-1:0];
        req_valid[i]    = 1'b1;
    endtask

    // One clock: sample at negedge, retire granted requests after the rising edge.
    task automatic step();
        logic [NREQ-1:0] hs;
        exp_t e;
        @(negedge clk);
        cyc++;
        hs = req_valid & req_ready;
        check("rdy_onehot", 64'($countones(req_ready) <= 1), 64'd1);
        if (|hs) hs_cyc = cyc;
        if (rsp_valid && !rv_prev) lat_obs = cyc - hs_cyc;
        rv_prev = rsp_valid;
        if (rsp_valid) check("rdy_in_resp", 64'(req_ready), 64'd0);
        if (rsp_valid && rsp_ready) begin
            n_rsp++;
            if (sb_q.size() == 0) begin
                check("unexpected_rsp", 64'(rsp_id), 64'hFFFF);
            end else begin
                e = sb_q.pop_front();
                check("rsp_id", 64'(rsp_id), 64'(e.id));
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_err", 64'(rsp_err), 64'(e.err));
            end
        end
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || req_valid != '0) && k < budget) begin
            step();
            k++;
        end
        check("drain_bound", 64'(k < budget), 64'd1);
    endtask

    task automatic check_reset_vals();
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_mul_start", 64'(mul_start), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_mul_a", 64'(mul_a), 64'd0);
        check("rst_mul_b", 64'(mul_b), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n0;
        reset     = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b1;

        // Contention: all four valid through reset, grants must go 0,1,2,3.
        set_req(0, 11, 2);
        set_req(1, -4, 6);
        set_req(2, 300, -7);
        set_req(3, -1000, -1000);
        expect_rsp(0, 32'd22, 1'b0);
        expect_rsp(1, 32'hFFFF_FFE8, 1'b0);
        expect_rsp(2, 32'hFFFF_F7CC, 1'b0);
        expect_rsp(3, 32'h000F_4240, 1'b0);
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 reset = 1'b0;
        drain(400);

        // ptr wrapped to 0 after id 3, so req0 beats req2.
        set_req(0, -3, 3);
        set_req(2, 5, 5);
        expect_rsp(0, 32'hFFFF_FFF7, 1'b0);
        expect_rsp(2, 32'd25, 1'b0);
        drain(200);

        // Single request, multiplier latency 8.
        mul_lat = 8;
        set_req(0, 3, -5);
        expect_rsp(0, 32'hFFFF_FFF1, 1'b0);
        drain(100);
        check("single_latency", 64'(lat_obs), 64'(2 + 8));

        // Backpressure: hold rsp_ready low for 10 cycles in RESP with another request pending.
        rsp_ready = 1'b0;
        set_req(1, 7, -9);
        expect_rsp(1, 32'hFFFF_FFC1, 1'b0);
        k = 0;
        while (!rsp_valid && k < 100) begin
            step();
            k++;
        end
        check("bp_reach_resp", 64'(rsp_valid), 64'd1);
        set_req(3, 12, 12);
        n0 = n_rsp;
        for (int c = 0; c < 10; c++) begin
            step();
            check("bp_valid", 64'(rsp_valid), 64'd1);
            check("bp_id", 64'(rsp_id), 64'd1);
            check("bp_data", 64'(rsp_data), 64'(32'hFFFF_FFC1));
            check("bp_err", 64'(rsp_err), 64'd0);
            check("bp_ready0", 64'(req_ready), 64'd0);
        end
        check("bp_no_hs", 64'(n_rsp), 64'(n0));
        rsp_ready = 1'b1;
        step();
        check("bp_one_hs", 64'(n_rsp - n0), 64'd1);
        expect_rsp(3, 32'd144, 1'b0);
        drain(100);

        // Timeout: done never arrives.
        mul_hang = 1'b1;
        set_req(1, 5, 6);
        expect_rsp(1, 32'd0, 1'b1);
        drain(200);
        check("timeout_latency", 64'(lat_obs), 64'(TIMEOUT + 2));
        mul_hang = 1'b0;
        mul_lat  = 3;
        set_req(3, -7, 9);
        expect_rsp(3, 32'hFFFF_FFC1, 1'b0);
        drain(100);

        // Extremes.
        set_req(0, -32768, -32768);
        expect_rsp(0, 32'h4000_0000, 1'b0);
        drain(100);
        set_req(1, 32767, -32768);
        expect_rsp(1, 32'hC000_8000, 1'b0);
        drain(100);

        // Reset during WAIT discards the operation.
        mul_lat = 20;
        set_req(2, 100, 200);
        repeat (6) step();
        check("pre_rst_busy", 64'(busy), 64'd1);
        reset     = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1 reset = 1'b0;
        rv_prev = 1'b0;
        n0 = n_rsp;
        repeat (30) step();
        check("rst_no_rsp", 64'(n_rsp), 64'(n0));
        mul_lat = 4;
        set_req(2, -100, 200);
        expect_rsp(2, 32'hFFFF_B1E0, 1'b0);
        drain(100);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
